hash_ctrl: RTL and testbench
============================

Name: hash_ctrl

Overview:
Sequencing controller for the 8 x 8-bit hash register bank (init_H / update_H / i_count / H_update interface).
- Accepts a message byte stream over a valid/ready handshake.
- Issues the bank initialisation, then performs NUM_ROUNDS compression rounds per byte, writing one H word per cycle.
- Pulses digest_valid when the final state is stable on the bank outputs.

Parameters:
NUM_ROUNDS, 2, compression rounds per message byte (1..15).
ROT, 1, left-rotate amount in the round function (0..7).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
start  in  1  begin a new hash (sampled only in IDLE)
msg_valid  in  1  message byte valid
msg_byte  in  8  message byte
msg_last  in  1  qualifies msg_byte as the final byte
msg_ready  out  1  controller can accept a byte
H_in  in  8x[0:7]  current H word array from the register bank
init_H  out  1  bank initialise strobe
update_H  out  1  bank write strobe
i_count  out  3  index of the H word being written
H_update  out  8  write data for H[i_count]
busy  out  1  high in any state other than IDLE
digest_valid  out  1  one-cycle pulse: H_in holds the final digest

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs = 0; internal byte latch, round counter, last flag and length counter = 0.
- IDLE: start=1 -> INIT. Otherwise stay.
- INIT: init_H=1 for exactly one cycle -> WAIT_BYTE.
- WAIT_BYTE: msg_ready=1.
  - On msg_valid & msg_ready: latch msg_byte and msg_last, clear i_count and the round counter, -> ROUND.
  - Without msg_valid: wait indefinitely.
- ROUND: one H word per cycle.
  - update_H=1.
  - H_update = rotl8(H_in[(i_count+2) mod 8] XOR latched_byte, ROT) XOR H_in[i_count].
  - i_count increments 0..7 and wraps to 0. Because H_in is read live, a later word sees earlier writes of the same round.
  - After i_count=7 the round counter increments.
  - After the last word of round NUM_ROUNDS-1: -> DONE if the last flag is set, otherwise -> WAIT_BYTE.
- DONE: update_H=0; digest_valid=1 for one cycle -> IDLE.
- Per-byte latency: 8*NUM_ROUNDS cycles from acceptance to the next msg_ready.
- init_H and update_H are never asserted in the same cycle.
- start outside IDLE is ignored; the hash is not restarted.
- msg_valid outside WAIT_BYTE is ignored; msg_ready=0, so the source must hold the byte.
- Message length is 1..255 bytes. An empty message is not supported: at least one byte with msg_last is required.
- i_count holds its last value while update_H=0; the bank ignores it.
- Reset asserted mid-ROUND: immediate return to IDLE with all strobes low; the bank contents are don't-care until the next INIT.

Optional Feature:
MSG_LEN_PAD_EN.
- Defined:
  - An 8-bit counter counts accepted bytes.
  - After the final byte's rounds, the controller runs one extra padding pass of NUM_ROUNDS rounds, with latched_byte = count (mod 256), then -> DONE.
  - Padding adds 8*NUM_ROUNDS cycles; msg_ready stays 0 during padding.
- Undefined: no counter and no padding pass; behaviour exactly as above.

Decomposition:
- Package hash_pkg:
  - state enum {IDLE, INIT, WAIT_BYTE, ROUND, PAD, DONE};
  - NUM_H=8 and H_W=8 constants;
  - a rotl8 function.
- Sub-module hash_round_fn: purely combinational computation of H_update from H_in, i_count, byte and ROT.
- The FSM and counters stay in hash_ctrl.

Test Plan:
- Reset then start=1:
  - init_H pulses once, exactly one cycle after start is sampled;
  - msg_ready rises the following cycle;
  - busy=1 throughout.
- Bank stubbed with H_in all 0x00, NUM_ROUNDS=2, ROT=1, one byte 0x01 with msg_last:
  - 16 update_H cycles; i_count sequence 0..7,0..7; H_update=0x02 every cycle;
  - digest_valid pulses once 17 cycles after acceptance;
  - then IDLE, busy=0.
- Live register model with 3 bytes 0xAA, 0x55, 0xFF (last):
  - msg_ready drops for 16 cycles after each acceptance;
  - final H_in matches the reference model;
  - msg_valid held during ROUND is not consumed.
- start pulsed during ROUND and during WAIT_BYTE: no extra init_H; the digest is identical to the undisturbed run.
- Reset asserted at i_count=4 of round 0: on the same edge all outputs are 0 and the state is IDLE; a new start re-inits and the hash completes normally.
- MSG_LEN_PAD_EN defined, 2 bytes:
  - a padding pass of 16 extra update_H cycles uses byte 0x02;
  - with all-zero H_in, H_update=0x04 for each padding word;
  - msg_ready=0 throughout padding.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types, bank geometry and the rotate helper for the hash bank controller.
package hash_pkg;

  localparam int NUM_H = 8;
  localparam int H_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_BYTE,
    ROUND,
    PAD,
    DONE
  } state_e;

  function automatic logic [H_W-1:0] rotl8(input logic [H_W-1:0] x, input logic [2:0] r);
    logic [2*H_W-1:0] d;
    d = {x, x} << r;
    return d[2*H_W-1:H_W];
  endfunction

endpackage

// File: rtl/hash_round_fn.sv
// Combinational round function: new value for word idx_i, reading the bank live so
// later words of a round observe earlier writes.
module hash_round_fn
  import hash_pkg::*;
#(
  parameter int unsigned ROT = 1
) (
  input  logic [H_W-1:0] h_i [0:NUM_H-1],
  input  logic [2:0]     idx_i,
  input  logic [H_W-1:0] byte_i,
  output logic [H_W-1:0] h_upd_o
);

  localparam logic [2:0] ROT_AMT = ROT[2:0];

  logic [2:0] src_idx;

  // 3-bit add wraps modulo 8, matching the bank size.
  assign src_idx = idx_i + 3'd2;
  assign h_upd_o = rotl8(h_i[src_idx] ^ byte_i, ROT_AMT) ^ h_i[idx_i];

endmodule

// File: rtl/hash_ctrl.sv
// hash_ctrl: sequences init/update strobes of an 8x8-bit hash register bank over a byte stream.
// Build option MSG_LEN_PAD_EN appends a length-padding pass after the final byte.
module hash_ctrl
  import hash_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 2,
  parameter int unsigned ROT        = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           msg_valid,
  input  logic [7:0]     msg_byte,
  input  logic           msg_last,
  output logic           msg_ready,
  input  logic [H_W-1:0] H_in [0:NUM_H-1],
  output logic           init_H,
  output logic           update_H,
  output logic [2:0]     i_count,
  output logic [H_W-1:0] H_update,
  output logic           busy,
  output logic           digest_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_e         state_q, state_d;
  logic [H_W-1:0] byte_q, byte_d;
  logic           last_q, last_d;
  logic [2:0]     i_q, i_d;
  logic [3:0]     round_q, round_d;
  logic           round_end;
  logic [H_W-1:0] word_upd;
`ifdef MSG_LEN_PAD_EN
  logic [7:0]     len_q, len_d;
`endif

  hash_round_fn #(.ROT(ROT)) u_round (
    .h_i    (H_in),
    .idx_i  (i_q),
    .byte_i (byte_q),
    .h_upd_o(word_upd)
  );

  assign round_end = (i_q == 3'd7) && (round_q == LAST_ROUND);
  assign i_count   = i_q;
  assign busy      = (state_q != IDLE);
  assign H_update  = update_H ? word_upd : '0;

  // msg_ready depends only on state; a byte transfers on any edge where msg_valid && msg_ready,
  // and the source must hold the byte while msg_ready is low.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    last_d       = last_q;
    i_d          = i_q;
    round_d      = round_q;
`ifdef MSG_LEN_PAD_EN
    len_d        = len_q;
`endif
    init_H       = 1'b0;
    update_H     = 1'b0;
    msg_ready    = 1'b0;
    digest_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        init_H  = 1'b1;
        state_d = WAIT_BYTE;
`ifdef MSG_LEN_PAD_EN
        len_d   = '0;
`endif
      end
      WAIT_BYTE: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          byte_d  = msg_byte;
          last_d  = msg_last;
          i_d     = '0;
          round_d = '0;
          state_d = ROUND;
`ifdef MSG_LEN_PAD_EN
          len_d   = len_q + 8'd1;
`endif
        end
      end
      ROUND, PAD: begin
        update_H = 1'b1;
        i_d      = i_q + 3'd1;
        if (i_q == 3'd7) round_d = round_q + 4'd1;
        if (round_end) begin
          if (state_q == PAD) begin
            state_d = DONE;
          end else if (!last_q) begin
            state_d = WAIT_BYTE;
          end else begin
`ifdef MSG_LEN_PAD_EN
            state_d = PAD;
            byte_d  = len_q;
            round_d = '0;
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
        digest_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      last_q  <= 1'b0;
      i_q     <= '0;
      round_q <= '0;
`ifdef MSG_LEN_PAD_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      i_q     <= i_d;
      round_q <= round_d;
`ifdef MSG_LEN_PAD_EN
      len_q   <= len_d;
`endif
    end
  end

endmodule

// File: tb/tb_hash_ctrl.sv
// Directed bench for hash_ctrl with a live 8x8-bit register bank model and a reference digest.
module tb_hash_ctrl;

  localparam int NR = 2;
`ifdef MSG_LEN_PAD_EN
  localparam int PAD_PASSES = 1;
`else
  localparam int PAD_PASSES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, msg_valid, msg_last;
  logic [7:0] msg_byte;
  logic       msg_ready, init_H, update_H, busy, digest_valid;
  logic [2:0] i_count;
  logic [7:0] H_update;
  logic [7:0] H_in [0:7];
  logic [7:0] bank_q [0:7];
  logic [7:0] iv [0:7] = '{8'h6A, 8'hBB, 8'h3C, 8'hA5, 8'h51, 8'h9B, 8'h1F, 8'h5B};
  logic [7:0] msg3 [0:2] = '{8'hAA, 8'h55, 8'hFF};
  logic [7:0] exp_h [0:7];
  logic [7:0] digest_keep [0:7];
  bit         stub;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         init_cnt = 0;

  hash_ctrl #(.NUM_ROUNDS(NR), .ROT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .msg_valid   (msg_valid),
    .msg_byte    (msg_byte),
    .msg_last    (msg_last),
    .msg_ready   (msg_ready),
    .H_in        (H_in),
    .init_H      (init_H),
    .update_H    (update_H),
    .i_count     (i_count),
    .H_update    (H_update),
    .busy        (busy),
    .digest_valid(digest_valid)
  );

  // clock / bank model
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) H_in[k] = stub ? 8'h00 : bank_q[k];
  end

  always @(posedge clk) begin
    if (init_H) begin
      for (int k = 0; k < 8; k++) bank_q[k] <= iv[k];
    end else if (update_H) begin
      bank_q[i_count] <= H_update;
    end
  end

  always @(negedge clk) if (init_H === 1'b1) init_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference digest from the round equation, ROT=1 written as a plain rotate
  task automatic compute_ref(input int n);
    logic [7:0] b, t;
    for (int k = 0; k < 8; k++) exp_h[k] = iv[k];
    for (int j = 0; j < n + PAD_PASSES; j++) begin
      b = (j < n) ? msg3[j] : 8'(n);
      for (int r = 0; r < NR; r++) begin
        for (int i = 0; i < 8; i++) begin
          t = exp_h[(i + 2) % 8] ^ b;
          exp_h[i] = {t[6:0], t[7]} ^ exp_h[i];
        end
      end
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic last);
    msg_valid = 1'b1;
    msg_byte  = b;
    msg_last  = last;
    for (int t = 0; t < 200 && msg_ready !== 1'b1; t++) @(negedge clk);
    n_cmp++;
    if (msg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_byte_timeout: msg_ready=%b exp=1", msg_ready);
    end
    @(negedge clk);
  endtask

  task automatic count_low(input bit pulse, output int n);
    n = 0;
    start = pulse;
    while (msg_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic count_digest(output int n);
    n = 0;
    while (digest_valid !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drive_msg3(input bit disturb, output int n0, output int n1, output int n2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    if (disturb) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_byte(msg3[0], 1'b0);
    msg_byte = msg3[1];
    count_low(disturb, n0);
    send_byte(msg3[1], 1'b0);
    msg_byte = msg3[2];
    msg_last = 1'b1;
    count_low(1'b0, n1);
    send_byte(msg3[2], 1'b1);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    count_digest(n2);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_byte = 8'h00; msg_last = 1'b0; stub = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({msg_ready, init_H, update_H, busy, digest_valid} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_strobes: got=%b exp=00000", {msg_ready, init_H, update_H, busy, digest_valid});
    end
    n_cmp++;
    if (i_count !== 3'd0) begin n_bad++; $display("FAIL reset_i_count: got=%0d exp=0", i_count); end
    n_cmp++;
    if (H_update !== 8'h00) begin n_bad++; $display("FAIL reset_H_update: got=%h exp=00", H_update); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || init_H !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b init_H=%b exp=0 0", busy, init_H);
    end
  endtask

  task automatic test_start_init();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (init_H !== 1'b1 || busy !== 1'b1 || msg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL init_cycle: init_H=%b busy=%b ready=%b exp=1 1 0", init_H, busy, msg_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (init_H !== 1'b0 || busy !== 1'b1 || msg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_cycle: init_H=%b busy=%b ready=%b exp=0 1 1", init_H, busy, msg_ready);
    end
  endtask

  task automatic test_single_byte_stub();
    stub = 1'b1;
    msg_valid = 1'b1; msg_byte = 8'h01; msg_last = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0;
    for (int k = 0; k < 16 * (1 + PAD_PASSES); k++) begin
      n_cmp++;
      if (update_H !== 1'b1 || i_count !== k[2:0] || H_update !== 8'h02 ||
          msg_ready !== 1'b0 || digest_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stub_round[%0d]: upd=%b i=%0d H=%h rdy=%b dv=%b exp=1 %0d 02 0 0",
                 k, update_H, i_count, H_update, msg_ready, digest_valid, k % 8);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (digest_valid !== 1'b1 || update_H !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stub_digest: dv=%b upd=%b busy=%b exp=1 0 1", digest_valid, update_H, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (digest_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stub_idle: dv=%b busy=%b exp=0 0", digest_valid, busy);
    end
  endtask

  task automatic test_live_msg();
    int n0, n1, n2, i0;
    stub = 1'b0;
    i0 = init_cnt;
    drive_msg3(1'b0, n0, n1, n2);
    compute_ref(3);
    n_cmp++;
    if (n0 !== 16 || n1 !== 16) begin
      n_bad++;
      $display("FAIL live_ready_low: got=%0d,%0d exp=16,16", n0, n1);
    end
    n_cmp++;
    if (n2 !== 16 * (1 + PAD_PASSES)) begin
      n_bad++;
      $display("FAIL live_digest_latency: got=%0d exp=%0d", n2, 16 * (1 + PAD_PASSES));
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (H_in[k] !== exp_h[k]) begin
        n_bad++;
        $display("FAIL live_digest[%0d]: got=%h exp=%h", k, H_in[k], exp_h[k]);
      end
      digest_keep[k] = exp_h[k];
    end
    n_cmp++;
    if (init_cnt - i0 !== 1) begin
      n_bad++;
      $display("FAIL live_init_count: got=%0d exp=1", init_cnt - i0);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n0, n1, n2, i0;
    stub = 1'b0;
    i0 = init_cnt;
    drive_msg3(1'b1, n0, n1, n2);
    n_cmp++;
    if (init_cnt - i0 !== 1) begin
      n_bad++;
      $display("FAIL disturb_init_count: got=%0d exp=1", init_cnt - i0);
    end
    n_cmp++;
    if (n0 !== 16 || n1 !== 16) begin
      n_bad++;
      $display("FAIL disturb_ready_low: got=%0d,%0d exp=16,16", n0, n1);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (H_in[k] !== digest_keep[k]) begin
        n_bad++;
        $display("FAIL disturb_digest[%0d]: got=%h exp=%h", k, H_in[k], digest_keep[k]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL disturb_idle: busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_round();
    int n0, n1, n2;
    stub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    send_byte(8'hAA, 1'b0);
    msg_valid = 1'b0;
    for (int t = 0; t < 50 && !(update_H === 1'b1 && i_count === 3'd4); t++) @(negedge clk);
    n_cmp++;
    if (update_H !== 1'b1 || i_count !== 3'd4) begin
      n_bad++;
      $display("FAIL midreset_reach: upd=%b i=%0d exp=1 4", update_H, i_count);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({msg_ready, init_H, update_H, busy, digest_valid} !== 5'b00000 ||
        i_count !== 3'd0 || H_update !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_outputs: strobes=%b i=%0d H=%h exp=00000 0 00",
               {msg_ready, init_H, update_H, busy, digest_valid}, i_count, H_update);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_msg3(1'b0, n0, n1, n2);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (H_in[k] !== digest_keep[k]) begin
        n_bad++;
        $display("FAIL midreset_digest[%0d]: got=%h exp=%h", k, H_in[k], digest_keep[k]);
      end
    end
    @(negedge clk);
  endtask

`ifdef MSG_LEN_PAD_EN
  task automatic test_pad();
    int n;
    stub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    send_byte(8'h10, 1'b0);
    msg_valid = 1'b0;
    count_low(1'b0, n);
    send_byte(8'h20, 1'b1);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (update_H !== 1'b1 || H_update !== 8'h04 || msg_ready !== 1'b0 || i_count !== k[2:0]) begin
        n_bad++;
        $display("FAIL pad_word[%0d]: upd=%b H=%h rdy=%b i=%0d exp=1 04 0 %0d",
                 k, update_H, H_update, msg_ready, i_count, k % 8);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (digest_valid !== 1'b1) begin n_bad++; $display("FAIL pad_digest: dv=%b exp=1", digest_valid); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_start_init();
    test_single_byte_stub();
    test_live_msg();
    test_start_ignored();
    test_reset_mid_round();
`ifdef MSG_LEN_PAD_EN
    test_pad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
